lpc_host_arbiter: RTL and testbench
===================================

# lpc_host_arbiter

Round-robin arbiter and sequencer that shares one `lpc_host` control port between `NUM_REQ` requesters. It latches one request at a time and drives the host's LFRAME/cycle-type handshake. It detects completion from the host's ready flag, returns read data or an error to the owning requester, and recovers a hung or aborted host with a timed reset pulse. It sits between firmware/bus-side clients (TPM driver, debug port) and `lpc_host`.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, legal 1..4.
- `TIMEOUT_CYCLES`, 64: cycles from LFRAME assertion to required completion, legal 16..255.
- `RESET_CYCLES`, 4: cycles `host_nrst_o` is held low on init/recovery, legal 1..15.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `nrst_i`  in  1  reset; asynchronous, active-low.
- `req_valid_i`  in  NUM_REQ  per-requester request, held until granted.
- `req_write_i`  in  NUM_REQ  1 = write, 0 = read.
- `req_mem_i`  in  NUM_REQ  1 = memory cycle, 0 = I/O cycle.
- `req_addr_i`  in  16*NUM_REQ  address; requester n at [16n+15:16n].
- `req_wdata_i`  in  8*NUM_REQ  write data; requester n at [8n+7:8n].
- `req_grant_o`  out  NUM_REQ  one-cycle pulse: request latched, fields may change.
- `rsp_valid_o`  out  NUM_REQ  one-cycle completion pulse to owner.
- `rsp_error_o`  out  1  qualifies rsp_valid_o: 1 = timeout.
- `rsp_rdata_o`  out  8  read data, valid with rsp_valid_o.
- `busy_o`  out  1  high in every state except IDLE.
- `host_nrst_o`, `host_lframe_o`, `host_rd_status_o`, `host_wr_status_o`, `host_memory_cycle_o`  out  1 each  to lpc_host ctrl inputs.
- `host_addr_o`  out  16, `host_data_o`  out  8  to lpc_host ctrl inputs.
- `host_data_i`  in  8, `host_ready_i`  in  1  from lpc_host.

## Operation
- All outputs are registered. Reset values: host_nrst_o=0, host_lframe_o=1, rd/wr status 0, memory_cycle 0, addr/data 0, grant/rsp_valid/rsp_error 0, rsp_rdata 0x00, busy_o 1. The round-robin pointer resets to NUM_REQ-1, so requester 0 wins first.
- States: INIT, IDLE, LFRAME, WAIT, HRESET, RECOVER.
- INIT: host_nrst_o low for RESET_CYCLES, then high -> RECOVER.
- IDLE: if any req_valid_i, select the first valid index after the pointer (modulo NUM_REQ). Latch its write/mem/addr/wdata into host_* outputs, update the pointer, and clear the timeout counter -> LFRAME. Grant pulses during LFRAME.
- LFRAME: host_lframe_o=0 for exactly one cycle -> WAIT.
- WAIT: host_lframe_o=1; host_rd_status_o = ~write, host_wr_status_o = write, both held until exit. Done = host_ready_i & ~ready_q, where ready_q is host_ready_i registered every cycle. A stale high ready level never counts as done.
  - On done: capture host_data_i (reads) or 0x00 (writes), set rsp_error_o=0 -> RECOVER.
  - If the counter reaches TIMEOUT_CYCLES first: rsp_rdata_o=0x00, rsp_error_o=1 -> HRESET.
- HRESET: status deasserted, host_nrst_o=0 for RESET_CYCLES -> RECOVER.
- RECOVER: status deasserted, lframe high, 2 cycles -> IDLE. rsp_valid_o[owner] pulses in the first RECOVER cycle after WAIT/HRESET, never after INIT.
- Requests arriving during a transaction wait; there is no preemption. A requester whose valid drops before grant is skipped.
- nrst_i low mid-transaction: immediate return to reset values; no response for the in-flight request.
- NUM_REQ=1: the pointer is constant and arbitration is trivial.

## Timing
- Request seen in IDLE at edge k: grant and lframe low in cycle k+1, status asserted from cycle k+2.
- Done detected at edge d: rsp_valid_o in cycle d+1; earliest next LFRAME in cycle d+4. This guarantees the host has returned to idle.
- Timeout counter counts cycles from LFRAME entry inclusive. Timeout response occurs at cycle TIMEOUT_CYCLES+1 after grant.
- Back-to-back same requester: a new grant is possible 3 cycles after its rsp_valid_o.

## Test plan
- After reset, host_nrst_o is low 4 cycles then high. Read requester 0, addr 0x0C00, host model returns 0xA5 -> grant[0] one cycle, lframe low one cycle, rd_status high, rsp_valid[0] with rdata 0xA5, error 0.
- Write requester 1, mem=1, addr 0x1234, wdata 0x5A -> host sees memory_cycle=1, wr_status=1, addr 0x1234, data 0x5A; rsp_valid[1], rdata 0x00.
- Both requesters valid continuously, NUM_REQ=2 -> grants alternate 0,1,0,1; no requester granted twice in a row while the other waits.
- Host ready held high from prior cycle, host stalled -> no false completion. After TIMEOUT_CYCLES: rsp_error=1, rdata 0x00, host_nrst_o low 4 cycles, then next request served normally.
- nrst_i asserted during WAIT -> outputs return to reset values asynchronously; no rsp_valid pulse; INIT sequence reruns after release.
- Requester 1 drops valid before grant while 0 is busy -> requester 1 never granted; pointer advances only on actual grants.

Source files
------------

// File: rtl/lpc_host_arbiter.sv
// Round-robin arbiter/sequencer sharing one lpc_host control port between NUM_REQ requesters.
// Drives the LFRAME/status handshake, returns read data or timeout errors, recovers the host with a reset pulse.
module lpc_host_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RESET_CYCLES   = 4
) (
  input  logic                  clk_i,
  input  logic                  nrst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ-1:0]    req_write_i,
  input  logic [NUM_REQ-1:0]    req_mem_i,
  input  logic [16*NUM_REQ-1:0] req_addr_i,
  input  logic [8*NUM_REQ-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]    req_grant_o,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  output logic                  rsp_error_o,
  output logic [7:0]            rsp_rdata_o,
  output logic                  busy_o,
  output logic                  host_nrst_o,
  output logic                  host_lframe_o,
  output logic                  host_rd_status_o,
  output logic                  host_wr_status_o,
  output logic                  host_memory_cycle_o,
  output logic [15:0]           host_addr_o,
  output logic [7:0]            host_data_o,
  input  logic [7:0]            host_data_i,
  input  logic                  host_ready_i
);

  // state   | meaning
  // INIT    | host held in reset after power-up
  // IDLE    | waiting for any requester
  // LFRAME  | one-cycle LFRAME low, grant pulse to owner
  // WAIT    | status asserted, waiting for ready edge or timeout
  // HRESET  | host reset pulse after timeout
  // RECOVER | two quiet cycles so the host settles back to idle
  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LFRAME, S_WAIT, S_HRESET, S_RECOVER
  } state_t;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t          state;
  logic [7:0]      tmr;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic            wr_q;
  logic            ready_q;
  logic            done;
  logic            sel_found;
  logic [PW-1:0]   sel_idx;
  logic [PW-1:0]   cand;

  // Lowest offset after the pointer wins, so scan offsets from the far end down.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr;
    cand      = ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = PW'((int'(ptr) + i) % NUM_REQ);
      if (req_valid_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Only a fresh rising ready counts; a level left high from earlier is ignored.
  assign done = host_ready_i & ~ready_q;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state               <= S_INIT;
      tmr                 <= 8'(RESET_CYCLES - 1);
      ptr                 <= PW'(NUM_REQ - 1);
      owner               <= '0;
      wr_q                <= 1'b0;
      ready_q             <= 1'b0;
      req_grant_o         <= '0;
      rsp_valid_o         <= '0;
      rsp_error_o         <= 1'b0;
      rsp_rdata_o         <= 8'h00;
      busy_o              <= 1'b1;
      host_nrst_o         <= 1'b0;
      host_lframe_o       <= 1'b1;
      host_rd_status_o    <= 1'b0;
      host_wr_status_o    <= 1'b0;
      host_memory_cycle_o <= 1'b0;
      host_addr_o         <= 16'h0000;
      host_data_o         <= 8'h00;
    end else begin
      ready_q     <= host_ready_i;
      req_grant_o <= '0;
      rsp_valid_o <= '0;
      case (state)
        S_INIT: begin
          if (tmr == 8'd0) begin
            host_nrst_o <= 1'b1;
            tmr         <= 8'd1;
            state       <= S_RECOVER;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        S_IDLE: begin
          if (sel_found) begin
            ptr                  <= sel_idx;
            owner                <= sel_idx;
            wr_q                 <= req_write_i[sel_idx];
            host_memory_cycle_o  <= req_mem_i[sel_idx];
            host_addr_o          <= req_addr_i[16*sel_idx +: 16];
            host_data_o          <= req_wdata_i[8*sel_idx +: 8];
            host_lframe_o        <= 1'b0;
            req_grant_o[sel_idx] <= 1'b1;
            tmr                  <= 8'(TIMEOUT_CYCLES);
            busy_o               <= 1'b1;
            state                <= S_LFRAME;
          end
        end
        S_LFRAME: begin
          host_lframe_o    <= 1'b1;
          host_rd_status_o <= ~wr_q;
          host_wr_status_o <= wr_q;
          tmr              <= tmr - 8'd1;
          state            <= S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            rsp_rdata_o        <= wr_q ? 8'h00 : host_data_i;
            rsp_error_o        <= 1'b0;
            rsp_valid_o[owner] <= 1'b1;
            host_rd_status_o   <= 1'b0;
            host_wr_status_o   <= 1'b0;
            tmr                <= 8'd1;
            state              <= S_RECOVER;
          end else if (tmr == 8'd0) begin
            rsp_rdata_o      <= 8'h00;
            rsp_error_o      <= 1'b1;
            host_rd_status_o <= 1'b0;
            host_wr_status_o <= 1'b0;
            host_nrst_o      <= 1'b0;
            tmr              <= 8'(RESET_CYCLES - 1);
            state            <= S_HRESET;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        S_HRESET: begin
          if (tmr == 8'd0) begin
            host_nrst_o        <= 1'b1;
            rsp_valid_o[owner] <= 1'b1;
            tmr                <= 8'd1;
            state              <= S_RECOVER;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        S_RECOVER: begin
          if (tmr == 8'd0) begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        default: begin
          host_nrst_o <= 1'b0;
          tmr         <= 8'(RESET_CYCLES - 1);
          busy_o      <= 1'b1;
          state       <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_host_arbiter.sv
// Directed bench for lpc_host_arbiter: reset/init, reads, writes, round-robin, timeout and mid-transaction reset.
module tb_lpc_host_arbiter;
  localparam int NR = 2;

  logic            clk_i = 1'b0;
  logic            nrst_i;
  logic [NR-1:0]   req_valid_i, req_write_i, req_mem_i;
  logic [16*NR-1:0] req_addr_i;
  logic [8*NR-1:0] req_wdata_i;
  logic [NR-1:0]   req_grant_o, rsp_valid_o;
  logic            rsp_error_o;
  logic [7:0]      rsp_rdata_o;
  logic            busy_o, host_nrst_o, host_lframe_o, host_rd_status_o, host_wr_status_o;
  logic            host_memory_cycle_o;
  logic [15:0]     host_addr_o;
  logic [7:0]      host_data_o, host_data_i;
  logic            host_ready_i;

  int n_chk = 0;
  int n_pass = 0;

  lpc_host_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(64), .RESET_CYCLES(4)) dut (
    .clk_i(clk_i), .nrst_i(nrst_i),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i), .req_mem_i(req_mem_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_grant_o(req_grant_o), .rsp_valid_o(rsp_valid_o), .rsp_error_o(rsp_error_o),
    .rsp_rdata_o(rsp_rdata_o), .busy_o(busy_o),
    .host_nrst_o(host_nrst_o), .host_lframe_o(host_lframe_o),
    .host_rd_status_o(host_rd_status_o), .host_wr_status_o(host_wr_status_o),
    .host_memory_cycle_o(host_memory_cycle_o), .host_addr_o(host_addr_o),
    .host_data_o(host_data_o), .host_data_i(host_data_i), .host_ready_i(host_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_grant(input logic [NR-1:0] exp, input string tag);
    int n = 0;
    while (req_grant_o == '0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, 32'(req_grant_o), 32'(exp));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, 32'(busy_o), 32'd0);
  endtask

  // Single-cycle ready edge; returns at the sample where the response must be visible.
  task automatic pulse_ready(input logic [7:0] d);
    host_data_i  = d;
    host_ready_i = 1'b1;
    @(negedge clk_i);
    host_ready_i = 1'b0;
  endtask

  task automatic count_init(output int cnt, output logic rseen);
    cnt = 0;
    rseen = 1'b0;
    while (!host_nrst_o && cnt < 20) begin
      cnt++;
      rseen |= |rsp_valid_o;
      @(negedge clk_i);
    end
  endtask

  task automatic txn(input int idx, input logic w, input logic m, input logic [15:0] a,
                     input logic [7:0] wd, input logic [7:0] rd, input string tag);
    logic [NR-1:0] onehot;
    onehot = NR'(1 << idx);
    req_write_i[idx] = w;
    req_mem_i[idx]   = m;
    req_addr_i[16*idx +: 16] = a;
    req_wdata_i[8*idx +: 8]  = wd;
    req_valid_i[idx] = 1'b1;
    wait_grant(onehot, {tag, "_grant"});
    chk({tag, "_lframe_lo"}, 32'(host_lframe_o), 32'd0);
    req_valid_i[idx] = 1'b0;
    @(negedge clk_i);
    chk({tag, "_grant_pulse"}, 32'(req_grant_o), 32'd0);
    chk({tag, "_lframe_hi"}, 32'(host_lframe_o), 32'd1);
    chk({tag, "_status"}, 32'({host_rd_status_o, host_wr_status_o}), 32'({~w, w}));
    chk({tag, "_addr"}, 32'(host_addr_o), 32'(a));
    chk({tag, "_mem"}, 32'(host_memory_cycle_o), 32'(m));
    if (w) chk({tag, "_wdata"}, 32'(host_data_o), 32'(wd));
    @(negedge clk_i);
    pulse_ready(rd);
    chk({tag, "_rsp"}, 32'(rsp_valid_o), 32'(onehot));
    chk({tag, "_rdata"}, 32'(rsp_rdata_o), w ? 32'h0 : 32'(rd));
    chk({tag, "_err"}, 32'(rsp_error_o), 32'd0);
    wait_idle({tag, "_idle"});
  endtask

  initial begin
    int n, cnt;
    logic rseen;
    logic [NR-1:0] gseen, exp_g;

    nrst_i = 1'b0;
    req_valid_i = '0; req_write_i = '0; req_mem_i = '0;
    req_addr_i = '0; req_wdata_i = '0;
    host_data_i = 8'h00; host_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_nrst", 32'(host_nrst_o), 32'd0);
    chk("rst_lframe", 32'(host_lframe_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd1);
    chk("rst_outs", 32'({req_grant_o, rsp_valid_o, rsp_error_o, rsp_rdata_o}), 32'd0);

    nrst_i = 1'b1;
    count_init(cnt, rseen);
    chk("init_len", 32'(cnt), 32'd4);
    wait_idle("init_idle");

    txn(0, 1'b0, 1'b0, 16'h0C00, 8'h00, 8'hA5, "rd0");
    txn(1, 1'b1, 1'b1, 16'h1234, 8'h5A, 8'hEE, "wr1");

    // Both requesters pending continuously: grants must alternate.
    req_write_i = '0; req_mem_i = '0;
    req_valid_i = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      while (req_grant_o == '0 && n < 100) begin
        @(negedge clk_i);
        n++;
      end
      chk("rr_grant", 32'(req_grant_o), 32'(exp_g));
      if (t > 0) chk("rr_gap", 32'(n), 32'd3);
      @(negedge clk_i);
      @(negedge clk_i);
      pulse_ready(8'h10 + 8'(t));
      chk("rr_rsp", 32'(rsp_valid_o), 32'(exp_g));
      chk("rr_rdata", 32'(rsp_rdata_o), 32'h10 + 32'(t));
    end
    req_valid_i = '0;
    wait_idle("rr_idle");

    // Stale ready level with a stalled host must time out, not complete.
    host_ready_i = 1'b1;
    host_data_i = 8'hC3;
    @(negedge clk_i);
    req_valid_i[0] = 1'b1;
    wait_grant(2'b01, "to_grant");
    req_valid_i[0] = 1'b0;
    n = 0;
    rseen = 1'b0;
    while (!rsp_error_o && n < 200) begin
      @(negedge clk_i);
      n++;
      rseen |= |rsp_valid_o;
    end
    chk("to_latency", 32'(n), 32'd65);
    chk("to_no_false_done", 32'(rseen), 32'd0);
    chk("to_rdata", 32'(rsp_rdata_o), 32'h0);
    chk("to_status_off", 32'({host_rd_status_o, host_wr_status_o}), 32'd0);
    count_init(cnt, rseen);
    chk("to_hreset_len", 32'(cnt), 32'd4);
    chk("to_rsp", 32'(rsp_valid_o), 32'b01);
    chk("to_err", 32'(rsp_error_o), 32'd1);
    host_ready_i = 1'b0;
    wait_idle("to_idle");
    txn(1, 1'b0, 1'b0, 16'h0C04, 8'h00, 8'h3C, "after_to");

    // Reset in the middle of WAIT: no response, INIT reruns.
    req_write_i[0] = 1'b0;
    req_addr_i[15:0] = 16'h0C08;
    req_valid_i[0] = 1'b1;
    wait_grant(2'b01, "mr_grant");
    req_valid_i[0] = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("mr_in_wait", 32'(host_rd_status_o), 32'd1);
    nrst_i = 1'b0;
    #1;
    chk("mr_nrst", 32'(host_nrst_o), 32'd0);
    chk("mr_status", 32'({host_rd_status_o, host_wr_status_o, host_lframe_o}), 32'b001);
    chk("mr_busy", 32'(busy_o), 32'd1);
    chk("mr_addr", 32'(host_addr_o), 32'h0);
    @(negedge clk_i);
    host_ready_i = 1'b1;
    @(negedge clk_i);
    host_ready_i = 1'b0;
    chk("mr_no_rsp_rst", 32'(rsp_valid_o), 32'd0);
    nrst_i = 1'b1;
    count_init(cnt, rseen);
    chk("mr_init_len", 32'(cnt), 32'd4);
    n = 0;
    while (busy_o && n < 50) begin
      rseen |= |rsp_valid_o;
      @(negedge clk_i);
      n++;
    end
    chk("mr_no_rsp", 32'(rseen), 32'd0);
    chk("mr_idle", 32'(busy_o), 32'd0);

    // Requester 1 withdraws before being granted; pointer must stay on 0.
    req_write_i = 2'b01;
    req_addr_i[15:0] = 16'h0080;
    req_wdata_i[7:0] = 8'h11;
    req_valid_i[0] = 1'b1;
    wait_grant(2'b01, "drop_g0");
    req_valid_i[0] = 1'b0;
    req_valid_i[1] = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    req_valid_i[1] = 1'b0;
    @(negedge clk_i);
    pulse_ready(8'h99);
    chk("drop_rsp0", 32'(rsp_valid_o), 32'b01);
    chk("drop_rdata0", 32'(rsp_rdata_o), 32'h0);
    gseen = '0;
    repeat (10) begin
      @(negedge clk_i);
      gseen |= req_grant_o;
    end
    chk("drop_no_grant", 32'(gseen), 32'd0);
    req_write_i = 2'b00;
    req_valid_i = 2'b11;
    wait_grant(2'b10, "drop_ptr");
    req_valid_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    pulse_ready(8'h77);
    chk("drop_rsp1", 32'(rsp_valid_o), 32'b10);
    chk("drop_rdata1", 32'(rsp_rdata_o), 32'h77);
    wait_idle("end_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
